// File: rtl/alu_issue_queue_pkg.sv
// Shared widths for the ALU issue queue: scoreboard id, per-entry payload fields, count width.
package alu_issue_queue_pkg;

  localparam int unsigned SCOREBOARD_SIZE_WIDTH = 4;

  localparam int unsigned PcW       = 64;
  localparam int unsigned InstW     = 32;
  localparam int unsigned FuncCodeW = 4;
  localparam int unsigned Xlen      = 64;

  localparam int unsigned IqDepth = 4;
  localparam int unsigned IqCntW  = $clog2(IqDepth + 1);

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/alu_iq_select.sv
// Find-first-set over the entry ready vector: lowest set bit wins (slot 0 is the oldest).
module alu_iq_select #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int unsigned IdxW = $clog2(N);

  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Age-ordered ALU issue queue: collects operands from writeback, issues the oldest ready op
// each cycle and compacts the remaining entries down.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IqDepth,
  parameter int unsigned SID_W = SCOREBOARD_SIZE_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         disp_valid_i,
  output logic                         disp_ready_o,
  input  logic [SID_W-1:0]             disp_sid_i,
  input  logic [2:0]                   disp_func3_i,
  input  logic                         disp_auipc_i,
  input  logic [PcW-1:0]               disp_pc_i,
  input  logic [InstW-1:0]             disp_inst_i,
  input  logic [FuncCodeW-1:0]         disp_func_code_i,
  input  logic                         disp_rs1_ready_i,
  input  logic                         disp_rs2_ready_i,
  input  logic [SID_W-1:0]             disp_rs1_sid_i,
  input  logic [SID_W-1:0]             disp_rs2_sid_i,
  input  logic [Xlen-1:0]              disp_rs1_value_i,
  input  logic [Xlen-1:0]              disp_rs2_value_i,
  input  logic                         wb_valid_i,
  input  logic [SID_W-1:0]             wb_sid_i,
  input  logic [Xlen-1:0]              wb_value_i,
  output logic                         alu_valid_o,
  output logic [SID_W-1:0]             alu_sid_o,
  output logic [2:0]                   alu_func3_o,
  output logic                         alu_auipc_o,
  output logic [PcW-1:0]               alu_pc_o,
  output logic [InstW-1:0]             alu_inst_o,
  output logic [Xlen-1:0]              rs1_value_o,
  output logic [Xlen-1:0]              rs2_value_o,
  output logic [FuncCodeW-1:0]         func_code_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef struct packed {
    logic             rdy;
    logic [SID_W-1:0] sid;
    logic [Xlen-1:0]  val;
  } src_t;

  typedef struct packed {
    logic [SID_W-1:0]     sid;
    logic [2:0]           func3;
    logic                 auipc;
    logic [PcW-1:0]       pc;
    logic [InstW-1:0]     inst;
    logic [FuncCodeW-1:0] func_code;
    src_t                 rs1;
    src_t                 rs2;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [DEPTH-1:0] req, gnt;
  logic [IdxW-1:0]  sel_idx;
  logic             sel_any;
  logic             issue, disp_fire;
  logic [CntW-1:0]  wr_idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = valid_q[i] & ent_q[i].rs1.rdy & ent_q[i].rs2.rdy;
    end
  end

  alu_iq_select #(
    .N (DEPTH)
  ) u_select (
    .req_i (req),
    .gnt_o (gnt),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  assign issue        = sel_any & ~flush_i;
  assign disp_ready_o = (count_q < CntW'(DEPTH));
  assign disp_fire    = disp_valid_i & disp_ready_o & ~flush_i;
  assign wr_idx       = count_q - CntW'(issue);
  assign count_d      = count_q - CntW'(issue) + CntW'(disp_fire);
  assign count_o      = count_q;

  assign alu_valid_o  = issue;
  assign alu_sid_o    = ent_q[sel_idx].sid;
  assign alu_func3_o  = ent_q[sel_idx].func3;
  assign alu_auipc_o  = ent_q[sel_idx].auipc;
  assign alu_pc_o     = ent_q[sel_idx].pc;
  assign alu_inst_o   = ent_q[sel_idx].inst;
  assign rs1_value_o  = ent_q[sel_idx].rs1.val;
  assign rs2_value_o  = ent_q[sel_idx].rs2.val;
  assign func_code_o  = ent_q[sel_idx].func_code;

  // Shift, then overlay the dispatch write, then apply wakeup to whatever lands in each slot.
  always_comb begin : next_state
    entry_t new_ent;
    logic   shift;
    int     src;
    new_ent.sid       = disp_sid_i;
    new_ent.func3     = disp_func3_i;
    new_ent.auipc     = disp_auipc_i;
    new_ent.pc        = disp_pc_i;
    new_ent.inst      = disp_inst_i;
    new_ent.func_code = disp_func_code_i;
    new_ent.rs1       = '{rdy: disp_rs1_ready_i, sid: disp_rs1_sid_i, val: disp_rs1_value_i};
    new_ent.rs2       = '{rdy: disp_rs2_ready_i, sid: disp_rs2_sid_i, val: disp_rs2_value_i};
    shift   = 1'b0;
    src     = 0;
    valid_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      shift = shift | (issue & gnt[i]);
      src   = (i + 1 < int'(DEPTH)) ? i + 1 : int'(DEPTH) - 1;
      if (shift) begin
        ent_d[i]   = ent_q[src];
        valid_d[i] = (i + 1 < int'(DEPTH)) ? valid_q[src] : 1'b0;
      end else begin
        ent_d[i]   = ent_q[i];
        valid_d[i] = valid_q[i];
      end
      if (disp_fire && (wr_idx == CntW'(i))) begin
        ent_d[i]   = new_ent;
        valid_d[i] = 1'b1;
      end
      if (wb_valid_i && !ent_d[i].rs1.rdy && (ent_d[i].rs1.sid == wb_sid_i)) begin
        ent_d[i].rs1.rdy = 1'b1;
        ent_d[i].rs1.val = wb_value_i;
      end
      if (wb_valid_i && !ent_d[i].rs2.rdy && (ent_d[i].rs2.sid == wb_sid_i)) begin
        ent_d[i].rs2.rdy = 1'b1;
        ent_d[i].rs2.val = wb_value_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Payload carries no reset; valid_q alone qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: per-cycle vector table plus throughput/wakeup sequences.
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned SidW  = SCOREBOARD_SIZE_WIDTH + 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush_i;
  logic                 disp_valid_i;
  logic                 disp_ready_o;
  logic [SidW-1:0]      disp_sid_i;
  logic [2:0]           disp_func3_i;
  logic                 disp_auipc_i;
  logic [PcW-1:0]       disp_pc_i;
  logic [InstW-1:0]     disp_inst_i;
  logic [FuncCodeW-1:0] disp_func_code_i;
  logic                 disp_rs1_ready_i, disp_rs2_ready_i;
  logic [SidW-1:0]      disp_rs1_sid_i, disp_rs2_sid_i;
  logic [Xlen-1:0]      disp_rs1_value_i, disp_rs2_value_i;
  logic                 wb_valid_i;
  logic [SidW-1:0]      wb_sid_i;
  logic [Xlen-1:0]      wb_value_i;
  logic                 alu_valid_o;
  logic [SidW-1:0]      alu_sid_o;
  logic [2:0]           alu_func3_o;
  logic                 alu_auipc_o;
  logic [PcW-1:0]       alu_pc_o;
  logic [InstW-1:0]     alu_inst_o;
  logic [Xlen-1:0]      rs1_value_o, rs2_value_o;
  logic [FuncCodeW-1:0] func_code_o;
  logic [CntW-1:0]      count_o;

  alu_issue_queue #(
    .DEPTH (Depth),
    .SID_W (SidW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush_i),
    .disp_valid_i     (disp_valid_i),
    .disp_ready_o     (disp_ready_o),
    .disp_sid_i       (disp_sid_i),
    .disp_func3_i     (disp_func3_i),
    .disp_auipc_i     (disp_auipc_i),
    .disp_pc_i        (disp_pc_i),
    .disp_inst_i      (disp_inst_i),
    .disp_func_code_i (disp_func_code_i),
    .disp_rs1_ready_i (disp_rs1_ready_i),
    .disp_rs2_ready_i (disp_rs2_ready_i),
    .disp_rs1_sid_i   (disp_rs1_sid_i),
    .disp_rs2_sid_i   (disp_rs2_sid_i),
    .disp_rs1_value_i (disp_rs1_value_i),
    .disp_rs2_value_i (disp_rs2_value_i),
    .wb_valid_i       (wb_valid_i),
    .wb_sid_i         (wb_sid_i),
    .wb_value_i       (wb_value_i),
    .alu_valid_o      (alu_valid_o),
    .alu_sid_o        (alu_sid_o),
    .alu_func3_o      (alu_func3_o),
    .alu_auipc_o      (alu_auipc_o),
    .alu_pc_o         (alu_pc_o),
    .alu_inst_o       (alu_inst_o),
    .rs1_value_o      (rs1_value_o),
    .rs2_value_o      (rs2_value_o),
    .func_code_o      (func_code_o),
    .count_o          (count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst_n;
    logic            flush;
    logic            dv;
    logic [SidW-1:0] dsid;
    logic            r1r;
    logic [SidW-1:0] r1s;
    logic [63:0]     r1v;
    logic            r2r;
    logic [SidW-1:0] r2s;
    logic [63:0]     r2v;
    logic            wv;
    logic [SidW-1:0] ws;
    logic [63:0]     wval;
    logic            ev;
    logic [SidW-1:0] esid;
    logic [63:0]     e1;
    logic [63:0]     e2;
    int              ecnt;
    logic            erdy;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Row builder: row() starts a cycle, disp()/wb() add stimulus, ex() records expectations.
  task automatic row();
    cur = '{default: 0};
    cur.rst_n = 1'b1;
  endtask

  task automatic disp(input int sid, input bit r1r, input int r1s, input logic [63:0] r1v,
                      input bit r2r, input int r2s, input logic [63:0] r2v);
    cur.dv = 1'b1;  cur.dsid = SidW'(sid);
    cur.r1r = r1r;  cur.r1s = SidW'(r1s);  cur.r1v = r1v;
    cur.r2r = r2r;  cur.r2s = SidW'(r2s);  cur.r2v = r2v;
  endtask

  task automatic wb(input int sid, input logic [63:0] val);
    cur.wv = 1'b1;  cur.ws = SidW'(sid);  cur.wval = val;
  endtask

  task automatic ex(input bit ev, input int esid, input logic [63:0] e1, input logic [63:0] e2,
                    input int ecnt, input bit erdy);
    cur.ev = ev;  cur.esid = SidW'(esid);  cur.e1 = e1;  cur.e2 = e2;
    cur.ecnt = ecnt;  cur.erdy = erdy;
    vecs.push_back(cur);
  endtask

  // Payload fields are derived from the op sid so they can be checked on issue.
  task automatic drive(input vec_t v);
    rst_n            = v.rst_n;
    flush_i          = v.flush;
    disp_valid_i     = v.dv;
    disp_sid_i       = v.dsid;
    disp_func3_i     = v.dsid[2:0];
    disp_auipc_i     = v.dsid[0];
    disp_pc_i        = {57'd0, v.dsid, 2'b00};
    disp_inst_i      = 32'h0100_0000 | {27'd0, v.dsid};
    disp_func_code_i = v.dsid[3:0];
    disp_rs1_ready_i = v.r1r;
    disp_rs1_sid_i   = v.r1s;
    disp_rs1_value_i = v.r1v;
    disp_rs2_ready_i = v.r2r;
    disp_rs2_sid_i   = v.r2s;
    disp_rs2_value_i = v.r2v;
    wb_valid_i       = v.wv;
    wb_sid_i         = v.ws;
    wb_value_i       = v.wval;
  endtask

  task automatic idle();
    row();
    drive(cur);
  endtask

  initial begin
    vec_t v;
    logic [SidW-1:0] s;
    int n;
    bit found;

    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset alu_valid", 64'(alu_valid_o), 64'd0);
    check("reset count", 64'(count_o), 64'd0);
    check("reset disp_ready", 64'(disp_ready_o), 64'd1);

    // Ready op: issues the next cycle.
    row(); disp(3, 1, 0, 5, 1, 0, 7);          ex(0, 0, 0, 0, 0, 1);
    row();                                     ex(1, 3, 5, 7, 1, 1);
    row();                                     ex(0, 0, 0, 0, 0, 1);
    // Younger ready op overtakes a waiting one; wakeup then issues the older.
    row(); disp(10, 0, 9, 0, 1, 0, 2);         ex(0, 0, 0, 0, 0, 1);
    row(); disp(11, 1, 0, 1, 1, 0, 1);         ex(0, 0, 0, 0, 1, 1);
    row(); wb(9, 64'h10);                      ex(1, 11, 1, 1, 2, 1);
    row();                                     ex(1, 10, 64'h10, 2, 1, 1);
    row();                                     ex(0, 0, 0, 0, 0, 1);
    // Fill with waiting ops; full stalls dispatch even while issuing.
    row(); disp(20, 0, 12, 0, 1, 0, 0);        ex(0, 0, 0, 0, 0, 1);
    row(); disp(21, 0, 13, 0, 1, 0, 0);        ex(0, 0, 0, 0, 1, 1);
    row(); disp(22, 0, 14, 0, 1, 0, 0);        ex(0, 0, 0, 0, 2, 1);
    row(); disp(23, 0, 15, 0, 1, 0, 0);        ex(0, 0, 0, 0, 3, 1);
    row(); disp(30, 1, 0, 1, 1, 0, 1); wb(14, 64'h44); ex(0, 0, 0, 0, 4, 0);
    row(); disp(31, 1, 0, 1, 1, 0, 1);         ex(1, 22, 64'h44, 0, 4, 0);
    row(); disp(24, 1, 0, 64'h55, 1, 0, 64'h66); ex(0, 0, 0, 0, 3, 1);
    row();                                     ex(1, 24, 64'h55, 64'h66, 4, 0);
    row(); wb(13, 64'h13);                     ex(0, 0, 0, 0, 3, 1);
    row(); wb(12, 64'h12);                     ex(1, 21, 64'h13, 0, 3, 1);
    row(); wb(15, 64'h15);                     ex(1, 20, 64'h12, 0, 2, 1);
    row();                                     ex(1, 23, 64'h15, 0, 1, 1);
    // Wakeup of the op being dispatched in the same cycle.
    row(); disp(5, 1, 0, 1, 0, 6, 0); wb(6, 64'hAB); ex(0, 0, 0, 0, 0, 1);
    row();                                     ex(1, 5, 1, 64'hAB, 1, 1);
    // Three ready ops, then flush with a concurrent dispatch.
    row(); disp(28, 0, 17, 0, 1, 0, 0);        ex(0, 0, 0, 0, 0, 1);
    row(); disp(29, 0, 17, 0, 1, 0, 0);        ex(0, 0, 0, 0, 1, 1);
    row(); disp(30, 0, 17, 0, 1, 0, 0); wb(17, 64'h77); ex(0, 0, 0, 0, 2, 1);
    row(); disp(31, 1, 0, 1, 1, 0, 1); cur.flush = 1'b1; ex(0, 0, 0, 0, 3, 1);
    row();                                     ex(0, 0, 0, 0, 0, 1);
    // Two ops on the same producer issue in age order.
    row(); disp(16, 0, 2, 0, 1, 0, 5);         ex(0, 0, 0, 0, 0, 1);
    row(); disp(17, 1, 0, 6, 0, 2, 0);         ex(0, 0, 0, 0, 1, 1);
    row(); wb(2, 64'h22);                      ex(0, 0, 0, 0, 2, 1);
    row();                                     ex(1, 16, 64'h22, 5, 2, 1);
    row();                                     ex(1, 17, 6, 64'h22, 1, 1);
    // Reset mid-operation drops the queue and the concurrent dispatch.
    row(); disp(18, 0, 25, 0, 1, 0, 0);        ex(0, 0, 0, 0, 0, 1);
    row(); disp(19, 1, 0, 1, 1, 0, 1); cur.rst_n = 1'b0; ex(0, 0, 0, 0, 1, 1);
    row();                                     ex(0, 0, 0, 0, 0, 1);
    row();                                     ex(0, 0, 0, 0, 0, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      @(negedge clk);
      drive(v);
      #1;
      check($sformatf("row%0d alu_valid", k), 64'(alu_valid_o), 64'(v.ev));
      check($sformatf("row%0d count", k), 64'(count_o), 64'(v.ecnt));
      check($sformatf("row%0d disp_ready", k), 64'(disp_ready_o), 64'(v.erdy));
      if (v.ev) begin
        s = v.esid;
        check($sformatf("row%0d sid", k), 64'(alu_sid_o), 64'(s));
        check($sformatf("row%0d rs1", k), rs1_value_o, v.e1);
        check($sformatf("row%0d rs2", k), rs2_value_o, v.e2);
        check($sformatf("row%0d pc", k), alu_pc_o, {57'd0, s, 2'b00});
        check($sformatf("row%0d func_code", k), 64'(func_code_o), 64'(s[3:0]));
        check($sformatf("row%0d inst", k), 64'(alu_inst_o), 64'(32'h0100_0000 | {27'd0, s}));
      end
    end

    // Back-to-back ready dispatches sustain one issue per cycle.
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      row();
      if (k < 4) disp(8 + k, 1, 0, 64'(k + 1), 1, 0, 64'(k + 2));
      drive(cur);
      #1;
      check($sformatf("thru%0d count", k), 64'(count_o), (k == 0) ? 64'd0 : 64'd1);
      check($sformatf("thru%0d alu_valid", k), 64'(alu_valid_o), (k == 0) ? 64'd0 : 64'd1);
      if (k > 0) begin
        check($sformatf("thru%0d sid", k), 64'(alu_sid_o), 64'(8 + k - 1));
        check($sformatf("thru%0d rs1", k), rs1_value_o, 64'(k));
      end
    end

    // Late wakeup: bounded wait, op must issue exactly one cycle after the broadcast.
    @(negedge clk);
    row(); disp(12, 0, 7, 0, 1, 0, 3); drive(cur);
    repeat (2) begin
      @(negedge clk);
      idle();
      #1;
      check("late idle alu_valid", 64'(alu_valid_o), 64'd0);
    end
    @(negedge clk);
    row(); wb(7, 64'h99); drive(cur);
    found = 1'b0;
    n = 0;
    for (int w = 0; w < 8 && !found; w++) begin
      @(negedge clk);
      idle();
      #1;
      if (alu_valid_o) begin
        found = 1'b1;
        n = w;
      end
    end
    check("late found", 64'(found), 64'd1);
    if (found) begin
      check("late wake latency", 64'(n), 64'd0);
      check("late rs1", rs1_value_o, 64'h99);
      check("late rs2", rs2_value_o, 64'd3);
    end
    @(negedge clk);
    #1;
    check("final count", 64'(count_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
